// File: rtl/pkg_dtypes.sv
// Shared datatypes for the instruction queue and its dispatch channels.
package pkg_dtypes;

  localparam int NUM_EXEC_TYPES = 4;

  typedef enum logic [1:0] {
    EXEC_UNIT = 2'd0,
    MUL_DIV   = 2'd1,
    LDR_STR   = 2'd2,
    BRANCH    = 2'd3
  } enum_instr_execution_type;

  typedef struct packed {
    enum_instr_execution_type exec_type;
    logic [5:0]               func;
  } type_opcode;

  typedef struct packed {
    type_opcode  opcode;
    logic [4:0]  rd;
    logic [15:0] imm;
  } type_iqueue_entry;

  typedef logic [NUM_EXEC_TYPES-1:0] type_exec_type_onehot;

  typedef enum logic [1:0] {
    EMPTY,
    PARTIAL,
    FULL
  } enum_iqueue_state;

endpackage

// File: rtl/iqueue_ptr_ctrl.sv
// Read/write pointers, occupancy count and EMPTY/PARTIAL/FULL state for the
// instruction queue.
module iqueue_ptr_ctrl
  import pkg_dtypes::*;
#(
  parameter int LOG2_DEPTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush_i,
  input  logic                  push_i,
  input  logic                  pop_i,
  output logic [LOG2_DEPTH-1:0] wr_ptr_o,
  output logic [LOG2_DEPTH-1:0] rd_ptr_o,
  output logic [LOG2_DEPTH:0]   count_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam logic [LOG2_DEPTH:0] DEPTH = {1'b1, {LOG2_DEPTH{1'b0}}};

  logic [LOG2_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [LOG2_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [LOG2_DEPTH:0]   count_q, count_d;
  enum_iqueue_state      state_q, state_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= EMPTY;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
    end
  end

  // Pointers wrap naturally at LOG2_DEPTH bits; flush overrides push and pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end

    if (count_d == '0)        state_d = EMPTY;
    else if (count_d == DEPTH) state_d = FULL;
    else                       state_d = PARTIAL;
  end

  assign wr_ptr_o = wr_ptr_q;
  assign rd_ptr_o = rd_ptr_q;
  assign count_o  = count_q;
  assign full_o   = (state_q == FULL);
  assign empty_o  = (state_q == EMPTY);

endmodule

// File: rtl/iqueue_dispatch.sv
// In-order instruction queue that presents its head to one of NUM_EXEC_TYPES
// dispatch channels. Optional same-cycle bypass when empty: IQUEUE_BYPASS_EN.
module iqueue_dispatch #(
  parameter int LOG2_DEPTH     = 3,
  parameter int NUM_EXEC_TYPES = pkg_dtypes::NUM_EXEC_TYPES
) (
  input  logic                                            clk,
  input  logic                                            reset,
  input  logic                                            flush,
  input  logic [$bits(pkg_dtypes::type_iqueue_entry)-1:0] in_entry,
  input  logic                                            in_valid,
  output logic                                            in_ready,
  output logic [$bits(pkg_dtypes::type_iqueue_entry)-1:0] out_entry,
  output logic [NUM_EXEC_TYPES-1:0]                       out_valid,
  input  logic [NUM_EXEC_TYPES-1:0]                       out_ready,
  output logic [LOG2_DEPTH:0]                             count,
  output logic                                            full,
  output logic                                            empty
);

  localparam int DEPTH = 2 ** LOG2_DEPTH;

  pkg_dtypes::type_iqueue_entry mem_q [DEPTH];
  pkg_dtypes::type_iqueue_entry in_e;
  pkg_dtypes::type_iqueue_entry head;
  logic [LOG2_DEPTH-1:0]        wr_ptr;
  logic [LOG2_DEPTH-1:0]        rd_ptr;
  logic [NUM_EXEC_TYPES-1:0]    head_oh;
  logic                         push;
  logic                         pop;
  logic                         bypass_take;

  assign in_e    = pkg_dtypes::type_iqueue_entry'(in_entry);
  assign head    = mem_q[rd_ptr];
  assign head_oh = NUM_EXEC_TYPES'(1) << head.opcode.exec_type;

`ifdef IQUEUE_BYPASS_EN
  logic                      bypass;
  logic [NUM_EXEC_TYPES-1:0] in_oh;

  // An empty queue forwards the incoming entry straight to its channel; if
  // that channel is ready the entry never touches storage.
  assign in_oh       = NUM_EXEC_TYPES'(1) << in_e.opcode.exec_type;
  assign bypass      = empty && in_valid && !flush && !reset;
  assign bypass_take = bypass && |(in_oh & out_ready);

  always_comb begin
    out_entry = head;
    out_valid = '0;
    if (bypass) begin
      out_entry = in_entry;
      out_valid = in_oh;
    end else if (!empty) begin
      out_valid = head_oh;
    end
  end
`else
  assign bypass_take = 1'b0;

  always_comb begin
    out_entry = head;
    out_valid = '0;
    if (!empty) out_valid = head_oh;
  end
`endif

  assign in_ready = !full;
  assign push     = in_valid && in_ready && !bypass_take;
  assign pop      = !empty && |(out_valid & out_ready);

  // Storage is not reset; occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr] <= in_e;
  end

  iqueue_ptr_ctrl #(
    .LOG2_DEPTH (LOG2_DEPTH)
  ) u_ptr_ctrl (
    .clk      (clk),
    .reset    (reset),
    .flush_i  (flush),
    .push_i   (push),
    .pop_i    (pop),
    .wr_ptr_o (wr_ptr),
    .rd_ptr_o (rd_ptr),
    .count_o  (count),
    .full_o   (full),
    .empty_o  (empty)
  );

endmodule

// File: tb/tb_iqueue_dispatch.sv
// Directed self-checking bench for iqueue_dispatch (default and bypass builds).
module tb_iqueue_dispatch;
  import pkg_dtypes::*;

  localparam int EW = $bits(type_iqueue_entry);

  logic          clk;
  logic          reset;
  logic          flush;
  logic [EW-1:0] inEntry;
  logic          inValid;
  logic          inReady;
  logic [EW-1:0] outEntry;
  logic [3:0]    outValid;
  logic [3:0]    outReady;
  logic [3:0]    count;
  logic          full;
  logic          empty;

  integer checkCount;
  integer errorCount;
  type_iqueue_entry expQ[$];

  iqueue_dispatch dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_entry  (inEntry),
    .in_valid  (inValid),
    .in_ready  (inReady),
    .out_entry (outEntry),
    .out_valid (outValid),
    .out_ready (outReady),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic type_iqueue_entry mkEntry(input int t, input int idx);
    type_iqueue_entry e;
    e.opcode.exec_type = enum_instr_execution_type'(t[1:0]);
    e.opcode.func      = 6'(idx);
    e.rd               = 5'(idx);
    e.imm              = 16'hA000 + 16'(idx);
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCount = checkCount + 1;
    if (got !== exp) begin
      errorCount = errorCount + 1;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input type_iqueue_entry e,
                               input logic [3:0] rdy, input logic fl);
    inValid  = v;
    inEntry  = e;
    outReady = rdy;
    flush    = fl;
    tick();
  endtask

  initial begin
    type_iqueue_entry e;
    checkCount = 0;
    errorCount = 0;
    reset    = 1'b1;
    flush    = 1'b0;
    inValid  = 1'b0;
    inEntry  = '0;
    outReady = '0;
    #3;
    checkOutput("rst_count", 64'(count), 64'd0);
    checkOutput("rst_empty", 64'(empty), 64'd1);
    checkOutput("rst_full", 64'(full), 64'd0);
    checkOutput("rst_in_ready", 64'(inReady), 64'd1);
    checkOutput("rst_out_valid", 64'(outValid), 64'd0);

    // Fill with exec types 0..3 twice while no channel is ready.
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      inEntry  = mkEntry(i % 4, i);
      inValid  = 1'b1;
      outReady = 4'b0000;
      if (i == 0) begin
        #1;
`ifdef IQUEUE_BYPASS_EN
        checkOutput("bypass_same_cycle_valid", 64'(outValid), 64'h1);
`else
        checkOutput("latency_pre_push_valid", 64'(outValid), 64'h0);
`endif
      end
      tick();
      if (i == 0) begin
        checkOutput("first_push_count", 64'(count), 64'd1);
        checkOutput("first_push_valid", 64'(outValid), 64'h1);
      end
    end
    inEntry = mkEntry(1, 99);
    #1;
    checkOutput("full_in_ready", 64'(inReady), 64'd0);
    tick();
    inValid = 1'b0;
    #1;
    checkOutput("full_count", 64'(count), 64'd8);
    checkOutput("full_flag", 64'(full), 64'd1);
    checkOutput("full_out_valid", 64'(outValid), 64'h1);
    checkOutput("full_head", 64'(outEntry), 64'(mkEntry(0, 0)));

    // Drain with every channel ready: strict push order.
    outReady = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      #1;
      checkOutput("drain_entry", 64'(outEntry), 64'(mkEntry(i % 4, i)));
      checkOutput("drain_valid", 64'(outValid), 64'(4'b0001 << (i % 4)));
      tick();
    end
    outReady = 4'b0000;
    #1;
    checkOutput("drain_count", 64'(count), 64'd0);
    checkOutput("drain_empty", 64'(empty), 64'd1);
    checkOutput("drain_out_valid", 64'(outValid), 64'h0);

    // LDR_STR head blocked by a ready mask lacking bit 2; BRANCH behind it waits.
    applyStimulus(1'b1, mkEntry(2, 20), 4'b0000, 1'b0);
    applyStimulus(1'b1, mkEntry(3, 21), 4'b0000, 1'b0);
    inValid  = 1'b0;
    outReady = 4'b1011;
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput("stall_valid", 64'(outValid), 64'h4);
      checkOutput("stall_entry", 64'(outEntry), 64'(mkEntry(2, 20)));
      checkOutput("stall_count", 64'(count), 64'd2);
      tick();
    end
    outReady = 4'b0100;
    tick();
    checkOutput("unstall_valid", 64'(outValid), 64'h8);
    checkOutput("unstall_entry", 64'(outEntry), 64'(mkEntry(3, 21)));
    checkOutput("unstall_count", 64'(count), 64'd1);
    outReady = 4'b1000;
    tick();
    outReady = 4'b0000;
    checkOutput("unstall_empty", 64'(empty), 64'd1);

    // Steady-state push+pop at occupancy 3; pointers wrap several times.
    for (int k = 0; k < 3; k++) begin
      e = mkEntry((30 + k) % 4, 30 + k);
      applyStimulus(1'b1, e, 4'b0000, 1'b0);
      expQ.push_back(e);
    end
    for (int k = 0; k < 20; k++) begin
      e        = mkEntry((33 + k) % 4, 33 + k);
      inEntry  = e;
      inValid  = 1'b1;
      outReady = 4'b1111;
      #1;
      checkOutput("wrap_head", 64'(outEntry), 64'(expQ[0]));
      checkOutput("wrap_count", 64'(count), 64'd3);
      tick();
      void'(expQ.pop_front());
      expQ.push_back(e);
    end
    inValid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checkOutput("wrap_tail", 64'(outEntry), 64'(expQ[0]));
      tick();
      void'(expQ.pop_front());
    end
    outReady = 4'b0000;
    checkOutput("wrap_end_empty", 64'(empty), 64'd1);

    // Flush with a concurrent push: everything, including the push, is lost.
    for (int k = 0; k < 5; k++) applyStimulus(1'b1, mkEntry(k % 4, 60 + k), 4'b0000, 1'b0);
    checkOutput("pre_flush_count", 64'(count), 64'd5);
    applyStimulus(1'b1, mkEntry(1, 65), 4'b0000, 1'b1);
    flush   = 1'b0;
    inValid = 1'b0;
    #1;
    checkOutput("flush_count", 64'(count), 64'd0);
    checkOutput("flush_empty", 64'(empty), 64'd1);
    checkOutput("flush_out_valid", 64'(outValid), 64'h0);
    applyStimulus(1'b1, mkEntry(3, 70), 4'b0000, 1'b0);
    inValid = 1'b0;
    #1;
    checkOutput("post_flush_entry", 64'(outEntry), 64'(mkEntry(3, 70)));
    checkOutput("post_flush_count", 64'(count), 64'd1);
    checkOutput("post_flush_valid", 64'(outValid), 64'h8);

    // Asynchronous reset in the middle of a push.
    inEntry = mkEntry(2, 71);
    inValid = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    checkOutput("midrst_count", 64'(count), 64'd0);
    checkOutput("midrst_empty", 64'(empty), 64'd1);
    checkOutput("midrst_full", 64'(full), 64'd0);
    checkOutput("midrst_in_ready", 64'(inReady), 64'd1);
    checkOutput("midrst_out_valid", 64'(outValid), 64'h0);
    @(negedge clk);
    reset   = 1'b0;
    inValid = 1'b0;
    tick();
    checkOutput("after_rst_count", 64'(count), 64'd0);

    // BRANCH entry into an empty queue with only the BRANCH channel ready.
    inEntry  = mkEntry(3, 80);
    inValid  = 1'b1;
    outReady = 4'b1000;
    #1;
`ifdef IQUEUE_BYPASS_EN
    checkOutput("bypass_valid", 64'(outValid), 64'h8);
    checkOutput("bypass_entry", 64'(outEntry), 64'(mkEntry(3, 80)));
    tick();
    inValid = 1'b0;
    #1;
    checkOutput("bypass_count", 64'(count), 64'd0);
    checkOutput("bypass_empty", 64'(empty), 64'd1);
`else
    checkOutput("nobypass_same_cycle", 64'(outValid), 64'h0);
    tick();
    inValid = 1'b0;
    #1;
    checkOutput("nobypass_next_valid", 64'(outValid), 64'h8);
    checkOutput("nobypass_next_entry", 64'(outEntry), 64'(mkEntry(3, 80)));
    checkOutput("nobypass_next_count", 64'(count), 64'd1);
    tick();
    checkOutput("nobypass_consumed", 64'(count), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/iqueue_dispatch.md
IQUEUE_DISPATCH -- requirements
Module: iqueue_dispatch

Interface
REQ-001 Parameter LOG2_DEPTH, default 3: queue holds 2**LOG2_DEPTH entries.
REQ-002 Parameter NUM_EXEC_TYPES, default 4: number of dispatch channels, one per enum_instr_execution_type value.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 flush  input  1  synchronous discard of all queued entries.
REQ-006 in_entry  input  $bits(type_iqueue_entry)  instruction to enqueue.
REQ-007 in_valid  input  1  in_entry is valid this cycle.
REQ-008 in_ready  output  1  queue accepts an entry this cycle.
REQ-009 out_entry  output  $bits(type_iqueue_entry)  head entry, shared by all channels.
REQ-010 out_valid  output  NUM_EXEC_TYPES  one-hot; bit index equals head opcode.exec_type.
REQ-011 out_ready  input  NUM_EXEC_TYPES  per-channel consumer ready.
REQ-012 count  output  LOG2_DEPTH+1  current occupancy.
REQ-013 full, empty  output  1 each  occupancy status flags.

Function
REQ-014 Push SHALL occur when in_valid && in_ready; in_ready SHALL equal !full, independent of same-cycle pop.
REQ-015 Pop SHALL occur when |(out_valid & out_ready); only the bit selected by the head's exec_type SHALL be considered.
REQ-016 When not empty, out_valid SHALL have exactly one bit set, at index out_entry.opcode.exec_type; when empty, out_valid SHALL be 0.
REQ-017 A pushed entry SHALL appear on out_entry no earlier than the cycle after the push (latency 1), bypass excepted (REQ-029).
REQ-018 Entries SHALL dispatch strictly in push order; a blocked head SHALL stall all later entries, including those of other exec types.
REQ-019 Read and write pointers are LOG2_DEPTH bits and SHALL wrap from 2**LOG2_DEPTH-1 to 0.
REQ-020 Simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-021 count SHALL increment on push-only and decrement on pop-only; full = (count == 2**LOG2_DEPTH), empty = (count == 0).
REQ-022 out_entry and out_valid SHALL be stable while out_valid is nonzero and no pop occurs.
REQ-023 A flush SHALL take priority over a same-cycle push and pop; the next cycle SHALL have count 0, pointers 0, and out_valid 0.
REQ-024 The push/pop/flush state machine SHALL have the states EMPTY, PARTIAL and FULL, with transitions driven solely by count after each edge.

Reset
REQ-025 On reset assertion, count, the pointers and out_valid SHALL be 0 immediately, and in_ready and empty SHALL be 1, full 0.
REQ-026 Reset mid-operation SHALL discard all stored entries; storage contents need not be cleared.
REQ-027 The first push after reset deassertion SHALL be accepted on the first rising edge at which reset is low.

Configuration
REQ-028 The macro IQUEUE_BYPASS_EN SHALL select the bypass feature.
REQ-029 With IQUEUE_BYPASS_EN defined, when empty && in_valid && !flush: out_entry = in_entry, and out_valid is the one-hot of in_entry's exec_type, in the same cycle. If the matching out_ready is high, the entry SHALL be consumed without being stored, and count SHALL be unchanged.
REQ-030 Without IQUEUE_BYPASS_EN, out_valid SHALL be 0 whenever empty, and the latency SHALL be exactly as in REQ-017.

Structure
REQ-031 localparam NUM_EXEC_TYPES and a typedef type_exec_type_onehot (NUM_EXEC_TYPES bits) SHALL be added to pkg_dtypes; the block SHALL use type_iqueue_entry and enum_instr_execution_type from pkg_dtypes.
REQ-032 Pointer and count logic SHALL live in one sub-module, iqueue_ptr_ctrl, parametrised by LOG2_DEPTH; storage and routing SHALL remain in iqueue_dispatch.

Verification
REQ-033 The bench SHALL push 8 entries with exec_type cycling EXEC_UNIT..BRANCH, holding out_ready = 0. Required: count reaches 8, full = 1, in_ready = 0, out_valid = 4'b0001.
REQ-034 From a full queue, the bench SHALL hold out_ready = 4'b1111 for 8 cycles. Required: entries exit in push order, out_valid follows exec_type 0,1,2,3,0,1,2,3, and the queue ends empty.
REQ-035 With the head's exec_type = LDR_STR and out_ready = 4'b1011, the bench SHALL run 3 cycles. Required: no pop, out_entry stable, out_valid = 4'b0100.
REQ-036 The bench SHALL run 20 cycles of push+pop with count held at 3. Required: count stays 3 and the pointers wrap past 7 with the data intact.
REQ-037 With 5 entries queued, the bench SHALL assert flush together with in_valid = 1. Required: count = 0 next cycle and the pushed entry is lost. It SHALL then assert reset mid-push. Required: outputs reach their reset values immediately.
REQ-038 With IQUEUE_BYPASS_EN, the bench SHALL drive an empty queue with in_valid = 1, exec_type = BRANCH and out_ready = 4'b1000. Required: out_valid = 4'b1000 in the same cycle and count remains 0. Without the macro, the required response is out_valid = 4'b1000 one cycle later.
